// File: rtl/load_store_unit_if.sv
// Core/memory-side bundle for load_store_unit: execute-stage request/response plus the data-memory port.
// The LSU connects through the slave modport; the core/memory environment uses master.
interface load_store_unit_if #(
    parameter int AW = 32
);
    logic          LsuReq;
    logic          LsuWr;
    logic [2:0]    LsuCtrl;
    logic [AW-1:0] LsuAddr;
    logic [31:0]   LsuDataWr;
    logic          LsuBusy;
    logic          LsuDone;
    logic          LsuFault;
    logic [31:0]   LsuDataRd;
    logic [AW-1:0] DMAddress;
    logic [31:0]   DMDataWr;
    logic          DMWr;
    logic [2:0]    DMCtrl;
    logic [31:0]   DMDataRd;

    modport slave (
        input  LsuReq, LsuWr, LsuCtrl, LsuAddr, LsuDataWr, DMDataRd,
        output LsuBusy, LsuDone, LsuFault, LsuDataRd,
        output DMAddress, DMDataWr, DMWr, DMCtrl
    );

    modport master (
        output LsuReq, LsuWr, LsuCtrl, LsuAddr, LsuDataWr, DMDataRd,
        input  LsuBusy, LsuDone, LsuFault, LsuDataRd,
        input  DMAddress, DMDataWr, DMWr, DMCtrl
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a byte-addressed big-endian data memory; misaligned accesses become byte beats.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned h/hu/w accesses fault instead of being split.
module load_store_unit #(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    localparam logic [2:0] DM_RB = 3'b100;
    localparam logic [2:0] DM_RH = 3'b101;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_SB = 3'b000;
    localparam logic [2:0] DM_SH = 3'b001;

    localparam logic [AW:0] DEPTH_W = {1'b0, AW'(DEPTH)};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          wr_q;
    logic [2:0]    ctrl_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          fault_q;
    logic          split_q;
    logic [2:0]    nbeats_q;
    logic [1:0]    beat_q;
    logic [23:0]   acc_q;
    logic [31:0]   rdata_q;

    logic [2:0]    size_chk;
    logic [AW:0]   end_addr;
    logic          aligned_chk;
    logic          fault_chk;
    logic          last_beat;
    logic [1:0]    lane;
    logic [7:0]    store_byte;
    logic [31:0]   rd_assembled;

    function automatic logic [2:0] size_of(input logic [2:0] c);
        case (c)
            CTRL_B, CTRL_BU: return 3'd1;
            CTRL_H, CTRL_HU: return 3'd2;
            CTRL_W:          return 3'd4;
            default:         return 3'd1;
        endcase
    endfunction

    function automatic logic legal_ctrl(input logic [2:0] c);
        return (c == CTRL_B) || (c == CTRL_H) || (c == CTRL_W) ||
               (c == CTRL_BU) || (c == CTRL_HU);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] v);
        case (c)
            CTRL_B:  return {{24{v[7]}}, v[7:0]};
            CTRL_BU: return {24'h0, v[7:0]};
            CTRL_H:  return {{16{v[15]}}, v[15:0]};
            CTRL_HU: return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Loads always read with unsigned sizes; sign handling happens in extend().
    function automatic logic [2:0] native_dm(input logic [2:0] c, input logic w);
        case (c)
            CTRL_B, CTRL_BU: return w ? DM_SB : DM_RB;
            CTRL_H, CTRL_HU: return w ? DM_SH : DM_RH;
            default:         return DM_W;
        endcase
    endfunction

    // End address is formed one bit wider so a huge address cannot wrap into range.
    always_comb begin
        size_chk    = size_of(ctrl_q);
        end_addr    = {1'b0, addr_q} + {{(AW-2){1'b0}}, size_chk} - {{AW{1'b0}}, 1'b1};
        aligned_chk = (size_chk == 3'd1) ||
                      ((size_chk == 3'd2) && !addr_q[0]) ||
                      ((size_chk == 3'd4) && (addr_q[1:0] == 2'b00));
        fault_chk   = !legal_ctrl(ctrl_q) || (end_addr >= DEPTH_W);
`ifdef LSU_MISALIGN_TRAP_EN
        fault_chk   = fault_chk || !aligned_chk;
`else
        fault_chk   = fault_chk || 1'b0;
`endif
    end

    assign last_beat    = ({1'b0, beat_q} == (nbeats_q - 3'd1));
    assign lane         = 2'(size_chk - 3'd1 - {1'b0, beat_q});
    assign store_byte   = wdata_q[{lane, 3'b000} +: 8];
    assign rd_assembled = split_q ? {acc_q, bus.DMDataRd[7:0]} : bus.DMDataRd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.LsuReq) state_d = CHECK;
            CHECK:   state_d = fault_chk ? DONE : XFER;
            XFER:    if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port is quiet (byte-read encoding, zero address/data) outside XFER.
    // DMWr is also gated by rst so a reset edge never completes a pending byte write.
    always_comb begin
        bus.DMAddress = '0;
        bus.DMDataWr  = 32'h0;
        bus.DMWr      = 1'b0;
        bus.DMCtrl    = DM_RB;
        if (state_q == XFER) begin
            bus.DMAddress = addr_q + AW'(beat_q);
            bus.DMWr      = wr_q && !rst;
            if (split_q) begin
                bus.DMCtrl   = wr_q ? DM_SB : DM_RB;
                bus.DMDataWr = wr_q ? {24'h0, store_byte} : 32'h0;
            end else begin
                bus.DMCtrl   = native_dm(ctrl_q, wr_q);
                bus.DMDataWr = wr_q ? wdata_q : 32'h0;
            end
        end
    end

    assign bus.LsuBusy   = (state_q != IDLE);
    assign bus.LsuDone   = (state_q == DONE);
    assign bus.LsuFault  = (state_q == DONE) && fault_q;
    assign bus.LsuDataRd = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if ((state_q == XFER) && last_beat && !wr_q) begin
                rdata_q <= extend(ctrl_q, rd_assembled);
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && bus.LsuReq) begin
            wr_q    <= bus.LsuWr;
            ctrl_q  <= bus.LsuCtrl;
            addr_q  <= bus.LsuAddr;
            wdata_q <= bus.LsuDataWr;
        end
        if (state_q == CHECK) begin
            fault_q  <= fault_chk;
            split_q  <= !aligned_chk;
            nbeats_q <= aligned_chk ? 3'd1 : size_chk;
            beat_q   <= 2'd0;
            acc_q    <= 24'h0;
        end
        // Byte beats shift in MSB first, matching big-endian memory order.
        if (state_q == XFER) begin
            beat_q <= beat_q + 2'd1;
            acc_q  <= rd_assembled[23:0];
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a scoreboard, plus reset-mid-store and idle checks.
module tb_load_store_unit;
    localparam int DEPTH = 64;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    always #5 clk = ~clk;

    load_store_unit_if #(.AW(AW)) bus ();
    load_store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] data;
        int          lat;
        int          wb;
        logic [2:0]  c1;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          lat;
        int          wb;
    } exp_t;

    vec_t        vt [26];
    exp_t        sb [$];
    logic [7:0]  mem [DEPTH];
    int          wr_beats;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = 32'h0;
    logic [5:0]  rd_a;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            5:  return 8'h80;
            8:  return 8'h12;
            9:  return 8'h34;
            10: return 8'h56;
            11: return 8'h78;
            12: return 8'h9A;
            19: return 8'hA5;
            20: return 8'hF0;
            21: return 8'h0F;
            22: return 8'h81;
            23: return 8'h7E;
            60: return 8'hDE;
            63: return 8'h7F;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
            wr_beats <= 0;
        end else if (bus.DMWr) begin
            wr_beats <= wr_beats + 1;
            case (bus.DMCtrl)
                3'b000: mem[bus.DMAddress[5:0]] <= bus.DMDataWr[7:0];
                3'b001: begin
                    mem[bus.DMAddress[5:0]]        <= bus.DMDataWr[15:8];
                    mem[bus.DMAddress[5:0] + 6'd1] <= bus.DMDataWr[7:0];
                end
                3'b010: begin
                    mem[bus.DMAddress[5:0]]        <= bus.DMDataWr[31:24];
                    mem[bus.DMAddress[5:0] + 6'd1] <= bus.DMDataWr[23:16];
                    mem[bus.DMAddress[5:0] + 6'd2] <= bus.DMDataWr[15:8];
                    mem[bus.DMAddress[5:0] + 6'd3] <= bus.DMDataWr[7:0];
                end
                default: ;
            endcase
        end
    end

    // Big-endian combinational read port.
    assign rd_a = bus.DMAddress[5:0];
    always_comb begin
        case (bus.DMCtrl)
            3'b100:  bus.DMDataRd = {24'h0, mem[rd_a]};
            3'b101:  bus.DMDataRd = {16'h0, mem[rd_a], mem[rd_a + 6'd1]};
            3'b010:  bus.DMDataRd = {mem[rd_a], mem[rd_a + 6'd1], mem[rd_a + 6'd2], mem[rd_a + 6'd3]};
            default: bus.DMDataRd = 32'h0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 1;
        endcase
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          wb0;
        logic        seen;
        logic [2:0]  c1;
        logic [31:0] a1;
        exp_t        e;
        exp_t        got;
        bus.LsuWr     = v.wr;
        bus.LsuCtrl   = v.ctrl;
        bus.LsuAddr   = v.addr;
        bus.LsuDataWr = v.wdata;
        bus.LsuReq    = 1'b1;
        lat = 0;
        while (bus.LsuBusy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.LsuBusy) begin
            bus.LsuReq = 1'b0;
            chk($sformatf("v%0d_accept_timeout", idx), 32'(bus.LsuBusy), 32'h0);
            return;
        end
        wb0 = wr_beats;
        @(posedge clk);
        #1;
        bus.LsuReq    = 1'b0;
        bus.LsuAddr   = $urandom;
        bus.LsuDataWr = $urandom;
        bus.LsuWr     = ~v.wr;
        bus.LsuCtrl   = 3'($urandom_range(0, 7));
        e.fault = v.fault;
        e.data  = (!v.wr && !v.fault) ? v.data : last_rd;
        e.lat   = v.lat;
        e.wb    = v.wb;
        sb.push_back(e);
        last_rd = e.data;
        seen = 1'b0;
        lat  = 0;
        c1   = 3'b111;
        a1   = 32'hFFFF_FFFF;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.LsuReq = 1'b1;
            if (lat == 2) begin
                bus.LsuReq = 1'b0;
                c1 = bus.DMCtrl;
                a1 = bus.DMAddress;
            end
            if (bus.LsuDone) seen = 1'b1;
        end
        bus.LsuReq = 1'b0;
        if (!seen) begin
            chk($sformatf("v%0d_done_timeout", idx), 32'(seen), 32'h1);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        chk($sformatf("v%0d_fault", idx), 32'(bus.LsuFault), 32'(got.fault));
        chk($sformatf("v%0d_data", idx), bus.LsuDataRd, got.data);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(got.lat));
        chk($sformatf("v%0d_write_beats", idx), 32'(wr_beats - wb0), 32'(got.wb));
        if (!got.fault) begin
            chk($sformatf("v%0d_beat1_ctrl", idx), 32'(c1), 32'(v.c1));
            chk($sformatf("v%0d_beat1_addr", idx), a1, v.addr);
        end
    endtask

    initial begin
        int   dones;
        int   sz;
        logic trap;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        //          wr    ctrl    addr          wdata         flt   data          lat wb  c1
        vt[0]  = '{1'b0, 3'b010, 32'd8,        32'h0,        1'b0, 32'h12345678, 3, 0, 3'b010};
        vt[1]  = '{1'b0, 3'b000, 32'd5,        32'h0,        1'b0, 32'hFFFFFF80, 3, 0, 3'b100};
        vt[2]  = '{1'b0, 3'b100, 32'd5,        32'h0,        1'b0, 32'h00000080, 3, 0, 3'b100};
        vt[3]  = '{1'b0, 3'b001, 32'd20,       32'h0,        1'b0, 32'hFFFFF00F, 3, 0, 3'b101};
        vt[4]  = '{1'b0, 3'b101, 32'd20,       32'h0,        1'b0, 32'h0000F00F, 3, 0, 3'b101};
        vt[5]  = '{1'b0, 3'b001, 32'd22,       32'h0,        1'b0, 32'hFFFF817E, 3, 0, 3'b101};
        vt[6]  = '{1'b0, 3'b001, 32'd21,       32'h0,        1'b0, 32'h00000F81, 4, 0, 3'b100};
        vt[7]  = '{1'b0, 3'b001, 32'd19,       32'h0,        1'b0, 32'hFFFFA5F0, 4, 0, 3'b100};
        vt[8]  = '{1'b0, 3'b101, 32'd19,       32'h0,        1'b0, 32'h0000A5F0, 4, 0, 3'b100};
        vt[9]  = '{1'b0, 3'b010, 32'd9,        32'h0,        1'b0, 32'h3456789A, 6, 0, 3'b100};
        vt[10] = '{1'b1, 3'b010, 32'd13,       32'hAABBCCDD, 1'b0, 32'h0,        6, 4, 3'b000};
        vt[11] = '{1'b0, 3'b010, 32'd13,       32'h0,        1'b0, 32'hAABBCCDD, 6, 0, 3'b100};
        vt[12] = '{1'b0, 3'b010, 32'd62,       32'h0,        1'b1, 32'h0,        2, 0, 3'b100};
        vt[13] = '{1'b0, 3'b011, 32'd0,        32'h0,        1'b1, 32'h0,        2, 0, 3'b100};
        vt[14] = '{1'b0, 3'b000, 32'd63,       32'h0,        1'b0, 32'h0000007F, 3, 0, 3'b100};
        vt[15] = '{1'b0, 3'b001, 32'd63,       32'h0,        1'b1, 32'h0,        2, 0, 3'b100};
        vt[16] = '{1'b0, 3'b010, 32'd60,       32'h0,        1'b0, 32'hDE00007F, 3, 0, 3'b010};
        vt[17] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0,        2, 0, 3'b100};
        vt[18] = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        2, 0, 3'b100};
        vt[19] = '{1'b1, 3'b000, 32'd40,       32'h123456EF, 1'b0, 32'h0,        3, 1, 3'b000};
        vt[20] = '{1'b1, 3'b001, 32'd42,       32'h0000BEEF, 1'b0, 32'h0,        3, 1, 3'b001};
        vt[21] = '{1'b0, 3'b010, 32'd40,       32'h0,        1'b0, 32'hEF00BEEF, 3, 0, 3'b010};
        vt[22] = '{1'b1, 3'b001, 32'd45,       32'h00001234, 1'b0, 32'h0,        4, 2, 3'b000};
        vt[23] = '{1'b0, 3'b101, 32'd45,       32'h0,        1'b0, 32'h00001234, 4, 0, 3'b100};
        vt[24] = '{1'b1, 3'b110, 32'd0,        32'h55667788, 1'b1, 32'h0,        2, 0, 3'b100};
        vt[25] = '{1'b0, 3'b010, 32'd8,        32'h0,        1'b0, 32'h12345678, 3, 0, 3'b010};
        // With the trap enabled, legal misaligned multi-byte accesses fault in CHECK.
        for (int i = 0; i < 26; i++) begin
            sz = size_of(vt[i].ctrl);
            if (trap && !vt[i].fault && sz > 1 && (vt[i].addr % sz) != 0) begin
                vt[i].fault = 1'b1;
                vt[i].lat   = 2;
                vt[i].wb    = 0;
            end
        end

        bus.LsuReq    = 1'b0;
        bus.LsuWr     = 1'b0;
        bus.LsuCtrl   = 3'b000;
        bus.LsuAddr   = 32'h0;
        bus.LsuDataWr = 32'h0;
        rst      = 1'b1;
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.LsuBusy), 32'h0);
        chk("reset_done", 32'(bus.LsuDone), 32'h0);
        chk("reset_fault", 32'(bus.LsuFault), 32'h0);
        chk("reset_datard", bus.LsuDataRd, 32'h0);
        chk("reset_dmaddr", bus.DMAddress, 32'h0);
        chk("reset_dmdatawr", bus.DMDataWr, 32'h0);
        chk("reset_dmwr", 32'(bus.DMWr), 32'h0);
        chk("reset_dmctrl", 32'(bus.DMCtrl), 32'h4);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) run_vec(i, vt[i]);

        chk("mem12_untouched", 32'(mem[12]), 32'h9A);
        chk("mem13", 32'(mem[13]), trap ? 32'h00 : 32'hAA);
        chk("mem14", 32'(mem[14]), trap ? 32'h00 : 32'hBB);
        chk("mem15", 32'(mem[15]), trap ? 32'h00 : 32'hCC);
        chk("mem16", 32'(mem[16]), trap ? 32'h00 : 32'hDD);
        chk("mem40", 32'(mem[40]), 32'hEF);
        chk("mem42", 32'(mem[42]), 32'hBE);
        chk("mem43", 32'(mem[43]), 32'hEF);
        chk("mem45", 32'(mem[45]), trap ? 32'h00 : 32'h12);
        chk("mem46", 32'(mem[46]), trap ? 32'h00 : 32'h34);
        chk("mem0_no_fault_write", 32'(mem[0]), 32'h00);

        // Reset during the second byte beat of a misaligned store (during CHECK when trapping).
        bus.LsuWr     = 1'b1;
        bus.LsuCtrl   = 3'b010;
        bus.LsuAddr   = 32'd33;
        bus.LsuDataWr = 32'h11223344;
        bus.LsuReq    = 1'b1;
        @(negedge clk);
        chk("rst_seq_idle_before", 32'(bus.LsuBusy), 32'h0);
        @(posedge clk);
        #1 bus.LsuReq = 1'b0;
        @(negedge clk);
        if (!trap) begin
            @(negedge clk);
            chk("rst_seq_beat1_dmwr", 32'(bus.DMWr), 32'h1);
            chk("rst_seq_beat1_addr", bus.DMAddress, 32'd33);
            chk("rst_seq_beat1_data", bus.DMDataWr, 32'h11);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("rst_seq_dmwr_in_reset", 32'(bus.DMWr), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_seq_busy", 32'(bus.LsuBusy), 32'h0);
        chk("rst_seq_dmwr", 32'(bus.DMWr), 32'h0);
        chk("rst_seq_mem33", 32'(mem[33]), trap ? 32'h00 : 32'h11);
        chk("rst_seq_mem34", 32'(mem[34]), 32'h00);
        chk("rst_seq_mem35", 32'(mem[35]), 32'h00);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.LsuDone) dones++;
            @(negedge clk);
        end
        chk("rst_seq_no_done", 32'(dones), 32'h0);
        chk("rst_seq_datard_reset", bus.LsuDataRd, 32'h0);
        last_rd = 32'h0;

        run_vec(25, vt[25]);

        dones = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.LsuDone || bus.LsuBusy) dones++;
        end
        chk("final_idle", 32'(dones), 32'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
